avalon_mm_csr_slave: RTL and testbench

AVALON_MM_CSR_SLAVE -- requirements
Module: avalon_mm_csr_slave

---
 rtl/avalon_mm_csr_slave.sv | 79 +++++++
 tb/tb_avalon_mm_csr_slave.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_csr_slave.sv
// avalon_mm_csr_slave: Avalon-MM CSR slave with RW control registers, RO status words
// and a fixed per-access waitrequest stall.
module avalon_mm_csr_slave #(
    parameter int DWIDTH      = 32,
    parameter int NUM_REGS    = 4,
    parameter int WAIT_CYCLES = 2,
    localparam int AWIDTH     = $clog2(NUM_REGS) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [AWIDTH-1:0]            address_i,
    input  logic                         write_i,
    input  logic [DWIDTH-1:0]            writedata_i,
    input  logic                         read_i,
    output logic                         waitrequest_o,
    output logic [DWIDTH-1:0]            readdata_o,
    output logic                         readdatavalid_o,
    output logic [NUM_REGS*DWIDTH-1:0]   ctrl_o,
    output logic [NUM_REGS-1:0]          wr_stb_o,
    input  logic [NUM_REGS*DWIDTH-1:0]   status_i
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DWIDTH-1:0]   ctrl_q [NUM_REGS];
    logic [DWIDTH-1:0]   ctrl_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d, rmux;
    logic                rvalid_q, rvalid_d;
    logic                req, accept;

    assign req           = read_i | write_i;
    assign accept        = req && cnt_q == 4'(WAIT_CYCLES);
    assign waitrequest_o = req && !accept;

    always_comb begin
        state_d  = (req && !accept) ? WAIT : IDLE;
        cnt_d    = (state_d == IDLE) ? 4'd0 : (state_q == IDLE) ? 4'd1 : cnt_q + 4'd1;
        rmux     = '0;
        ctrl_d   = ctrl_q;
        wr_stb_d = '0;
        ctrl_o   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (address_i == AWIDTH'(k)) rmux = ctrl_q[k];
            if (address_i == AWIDTH'(k + NUM_REGS)) rmux = status_i[k*DWIDTH +: DWIDTH];
            if (accept && write_i && address_i == AWIDTH'(k)) begin
                ctrl_d[k]   = writedata_i;
                wr_stb_d[k] = 1'b1;
            end
            ctrl_o[k*DWIDTH +: DWIDTH] = ctrl_q[k];
        end
        // write wins when both requests are accepted together
        rvalid_d = accept && read_i && !write_i;
        rdata_d  = rvalid_d ? rmux : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ctrl_q   <= '{default: '0};
            wr_stb_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            wr_stb_q <= wr_stb_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign wr_stb_o        = wr_stb_q;
    assign readdata_o      = rdata_q;
    assign readdatavalid_o = rvalid_q;
endmodule

// File: tb/tb_avalon_mm_csr_slave.sv
// tb_avalon_mm_csr_slave: directed bench for the CSR slave, WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_avalon_mm_csr_slave;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   addr, addr0;
    logic         wr, wr0, rd, rd0;
    logic [31:0]  wdata, wdata0;
    logic [127:0] status, status0;
    logic         waitreq, waitreq0, rdv, rdv0;
    logic [31:0]  rdata, rdata0;
    logic [127:0] ctrl, ctrl0;
    logic [3:0]   stb, stb0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    avalon_mm_csr_slave #(.DWIDTH(32), .NUM_REGS(4), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .address_i(addr), .write_i(wr), .writedata_i(wdata),
        .read_i(rd), .waitrequest_o(waitreq), .readdata_o(rdata), .readdatavalid_o(rdv),
        .ctrl_o(ctrl), .wr_stb_o(stb), .status_i(status)
    );

    avalon_mm_csr_slave #(.DWIDTH(32), .NUM_REGS(4), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .address_i(addr0), .write_i(wr0), .writedata_i(wdata0),
        .read_i(rd0), .waitrequest_o(waitreq0), .readdata_o(rdata0), .readdatavalid_o(rdv0),
        .ctrl_o(ctrl0), .wr_stb_o(stb0), .status_i(status0)
    );

    task automatic test_reset();
        rst_n = 1'b0; addr = 0; wr = 0; rd = 0; wdata = 0; status = '0;
        addr0 = 0; wr0 = 0; rd0 = 0; wdata0 = 0; status0 = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ctrl !== 128'h0) begin n_err++; $display("FAIL rst_ctrl: got %h want 0", ctrl); end
        n_cmp++; if (stb !== 4'h0) begin n_err++; $display("FAIL rst_stb: got %b want 0000", stb); end
        n_cmp++; if (rdv !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL rst_rd: got rdv=%b rdata=%h want 0/0", rdv, rdata); end
        n_cmp++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL rst_wait_idle: got %b want 0", waitreq); end
        rd = 1'b1;
        #1;
        n_cmp++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL rst_wait_req: got %b want 1", waitreq); end
        rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        addr = 3'd1; wdata = 32'hA5A5_0001; wr = 1'b1;
        #1;
        n_cmp++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL wr_wait_c0: got %b want 1", waitreq); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL wr_wait_c1: got %b want 1", waitreq); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL wr_wait_c2: got %b want 0", waitreq); end
        n_cmp++; if (ctrl[63:32] !== 32'h0 || stb !== 4'b0000) begin n_err++; $display("FAIL wr_pre_accept: got ctrl1=%h stb=%b want 0/0000", ctrl[63:32], stb); end
        @(negedge clk);
        wr = 1'b0;
        n_cmp++; if (ctrl !== {64'h0, 32'hA5A5_0001, 32'h0}) begin n_err++; $display("FAIL wr_ctrl: got %h want A5A50001 in word1", ctrl); end
        n_cmp++; if (stb !== 4'b0010) begin n_err++; $display("FAIL wr_stb: got %b want 0010", stb); end
        @(negedge clk);
        n_cmp++; if (stb !== 4'b0000) begin n_err++; $display("FAIL wr_stb_end: got %b want 0000", stb); end
    endtask

    task automatic test_read();
        addr = 3'd1; rd = 1'b1;
        #1;
        n_cmp++; if (waitreq !== 1'b1 || rdv !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL rd_c0: got wait=%b rdv=%b rdata=%h want 1/0/0", waitreq, rdv, rdata); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b1 || rdv !== 1'b0) begin n_err++; $display("FAIL rd_c1: got wait=%b rdv=%b want 1/0", waitreq, rdv); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b0 || rdv !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL rd_c2: got wait=%b rdv=%b rdata=%h want 0/0/0", waitreq, rdv, rdata); end
        @(negedge clk);
        rd = 1'b0;
        n_cmp++; if (rdv !== 1'b1 || rdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL rd_data: got rdv=%b rdata=%h want 1/A5A50001", rdv, rdata); end
        @(negedge clk);
        n_cmp++; if (rdv !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL rd_after: got rdv=%b rdata=%h want 0/0", rdv, rdata); end
    endtask

    task automatic test_status();
        status[95:64] = 32'h1234_5678;
        addr = 3'd6; rd = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL st_rd_wait: got %b want 0", waitreq); end
        @(negedge clk);
        rd = 1'b0;
        n_cmp++; if (rdv !== 1'b1 || rdata !== 32'h1234_5678) begin n_err++; $display("FAIL st_rd_data: got rdv=%b rdata=%h want 1/12345678", rdv, rdata); end
        wdata = 32'hFFFF_FFFF; wr = 1'b1;
        repeat (3) @(negedge clk);
        wr = 1'b0;
        n_cmp++; if (ctrl !== {64'h0, 32'hA5A5_0001, 32'h0} || stb !== 4'b0000) begin n_err++; $display("FAIL st_wr_ignored: got ctrl=%h stb=%b want unchanged/0000", ctrl, stb); end
        @(negedge clk);
        n_cmp++; if (stb !== 4'b0000 || rdv !== 1'b0) begin n_err++; $display("FAIL st_wr_after: got stb=%b rdv=%b want 0000/0", stb, rdv); end
    endtask

    task automatic test_both();
        addr = 3'd0; wdata = 32'h7; wr = 1'b1; rd = 1'b1;
        repeat (3) @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        n_cmp++; if (ctrl[31:0] !== 32'h7 || stb !== 4'b0001) begin n_err++; $display("FAIL both_wr: got ctrl0=%h stb=%b want 7/0001", ctrl[31:0], stb); end
        n_cmp++; if (rdv !== 1'b0) begin n_err++; $display("FAIL both_rdv: got %b want 0", rdv); end
        @(negedge clk);
        n_cmp++; if (rdv !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL both_rdv_next: got rdv=%b rdata=%h want 0/0", rdv, rdata); end
    endtask

    task automatic test_drop();
        addr = 3'd1; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        #1;
        n_cmp++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL drop_wait: got %b want 0", waitreq); end
        @(negedge clk);
        rd = 1'b1;
        #1;
        n_cmp++; if (waitreq !== 1'b1 || rdv !== 1'b0) begin n_err++; $display("FAIL drop_restart_c0: got wait=%b rdv=%b want 1/0", waitreq, rdv); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL drop_restart_c1: got %b want 1", waitreq); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL drop_restart_c2: got %b want 0", waitreq); end
        @(negedge clk);
        rd = 1'b0;
        n_cmp++; if (rdv !== 1'b1 || rdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL drop_data: got rdv=%b rdata=%h want 1/A5A50001", rdv, rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        int waits = 0;
        wr0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr0 = 3'(i); wdata0 = vals[i];
            #1; if (waitreq0) waits++;
            @(negedge clk);
        end
        wr0 = 1'b0;
        n_cmp++; if (ctrl0 !== {32'h44, 32'h33, 32'h22, 32'h11}) begin n_err++; $display("FAIL b2b_ctrl: got %h want 00000044000000330000002200000011", ctrl0); end
        rd0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                n_cmp++; if (rdv0 !== 1'b1 || rdata0 !== vals[i-1]) begin n_err++; $display("FAIL b2b_rd%0d: got rdv=%b rdata=%h want 1/%h", i-1, rdv0, rdata0, vals[i-1]); end
            end
            if (i == 4) rd0 = 1'b0;
            else addr0 = 3'(i);
            #1; if (waitreq0) waits++;
            @(negedge clk);
        end
        n_cmp++; if (rdv0 !== 1'b0 || rdata0 !== 32'h0) begin n_err++; $display("FAIL b2b_end: got rdv=%b rdata=%h want 0/0", rdv0, rdata0); end
        n_cmp++; if (waits !== 0) begin n_err++; $display("FAIL b2b_wait: got %0d stalled cycles want 0", waits); end
    endtask

    task automatic test_reset_mid();
        addr = 3'd2; wdata = 32'h0000_BEEF; wr = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ctrl !== 128'h0 || stb !== 4'h0 || rdv !== 1'b0) begin n_err++; $display("FAIL rstm_clear: got ctrl=%h stb=%b rdv=%b want 0/0/0", ctrl, stb, rdv); end
        n_cmp++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL rstm_wait: got %b want 1", waitreq); end
        @(negedge clk);
        n_cmp++; if (ctrl !== 128'h0 || stb !== 4'h0) begin n_err++; $display("FAIL rstm_hold: got ctrl=%h stb=%b want 0/0", ctrl, stb); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (waitreq !== 1'b1) begin n_err++; $display("FAIL rstm_c0: got %b want 1", waitreq); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b1 || stb !== 4'h0) begin n_err++; $display("FAIL rstm_c1: got wait=%b stb=%b want 1/0000", waitreq, stb); end
        @(negedge clk); #1;
        n_cmp++; if (waitreq !== 1'b0) begin n_err++; $display("FAIL rstm_c2: got %b want 0", waitreq); end
        @(negedge clk);
        wr = 1'b0;
        n_cmp++; if (ctrl !== {32'h0, 32'h0000_BEEF, 64'h0} || stb !== 4'b0100) begin n_err++; $display("FAIL rstm_wr: got ctrl=%h stb=%b want BEEF in word2/0100", ctrl, stb); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_status();
        test_both();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
